// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Purpose  : Front-end fetch stage. Owns the PC and the instruction register,
//            fetches one word at a time from instruction memory over a
//            req/ready handshake, holds it until decode accepts it, then
//            advances the PC to PC+4, the branch target or the jump target.
//            opcode (instr[31:26]) feeds the control unit.
// Ports    : clk, rst_n                 - clock, synchronous active-low reset
//            imem_req/addr/rdata/ready  - instruction memory handshake
//            instr, opcode, instr_valid - fetched word towards decode
//            instr_ready                - decode accepts instr this cycle
//            pc, pc_plus4               - address of instr and its successor
//            jump, jump_index           - jump redirect for retiring instr
//            branch, zero, branch_offset- conditional branch redirect
//            fetch_count, stall_count   - only with IF_PERF_CNT_EN defined
// Config   : IF_PERF_CNT_EN - adds accepted-fetch and issue-stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_rdata,
  input  logic               imem_ready,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        fetch_count,
  output logic [31:0]        stall_count,
`endif
  input  logic               jump,
  input  logic [25:0]        jump_index,
  input  logic               branch,
  input  logic               zero,
  input  logic [15:0]        branch_offset
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;

  logic [31:0] pc_plus4_w;
  logic [31:0] branch_target_w;
  logic [31:0] jump_target_w;
  logic [31:0] next_pc_w;

  // All adds are 32-bit; carry out is dropped so the PC wraps.
  assign pc_plus4_w      = pc_q + 32'd4;
  assign branch_target_w = pc_plus4_w + {{14{branch_offset[15]}}, branch_offset, 2'b00};
  assign jump_target_w   = {pc_plus4_w[31:28], jump_index, 2'b00};

  // Jump outranks branch when both are asserted.
  always_comb begin
    next_pc_w = pc_plus4_w;
    if (jump) begin
      next_pc_w = jump_target_w;
    end else if (branch && zero) begin
      next_pc_w = branch_target_w;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      BOOT: begin
        state_d = FETCH;
      end
      FETCH: begin
        if (imem_ready) begin
          instr_d = imem_rdata;
          valid_d = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Redirect inputs only matter on the accepting cycle.
        if (instr_ready) begin
          pc_d    = next_pc_w;
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      default: begin
        state_d = BOOT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    if (state_q == ISSUE) begin
      if (instr_ready) begin
        fetch_count_d = fetch_count_q + 32'd1;
      end else begin
        stall_count_d = stall_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_count_q <= 32'h0;
      stall_count_q <= 32'h0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif

  // The request is a pure decode of the state register, so it drops
  // immediately on reset and stays stable for the whole FETCH state.
  assign imem_req    = (state_q == FETCH);
  assign imem_addr   = {pc_q[IMEM_AW-1:2], 2'b00};
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = valid_q;
  assign pc          = pc_q;
  assign pc_plus4    = pc_plus4_w;

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_fetch
// Purpose  : Directed self-checking bench for instruction_fetch. Memory
//            returns the bitwise inverse of the fetch address, so every
//            expected instruction word follows from the expected address.
//            A second instance with RESET_PC = 32'h4000_0000 exercises the
//            upper PC nibble in the jump target.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_ready;
  logic        instr_ready;
  logic        jump;
  logic [25:0] jump_index;
  logic        branch;
  logic        zero;
  logic [15:0] branch_offset;

  logic        imem_req,   hi_imem_req;
  logic [31:0] imem_addr,  hi_imem_addr;
  logic [31:0] imem_rdata, hi_imem_rdata;
  logic [31:0] instr,      hi_instr;
  logic [5:0]  opcode,     hi_opcode;
  logic        instr_valid, hi_instr_valid;
  logic [31:0] pc,         hi_pc;
  logic [31:0] pc_plus4,   hi_pc_plus4;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_count, hi_fetch_count;
  logic [31:0] stall_count, hi_stall_count;
`endif

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  assign imem_rdata    = ~imem_addr;
  assign hi_imem_rdata = ~hi_imem_addr;

  instruction_fetch #(.RESET_PC(32'h0000_0000), .IMEM_AW(32)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .instr(instr), .opcode(opcode), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .pc(pc), .pc_plus4(pc_plus4),
`ifdef IF_PERF_CNT_EN
    .fetch_count(fetch_count), .stall_count(stall_count),
`endif
    .jump(jump), .jump_index(jump_index), .branch(branch),
    .zero(zero), .branch_offset(branch_offset)
  );

  instruction_fetch #(.RESET_PC(32'h4000_0000), .IMEM_AW(32)) u_dut_hi (
    .clk(clk), .rst_n(rst_n),
    .imem_req(hi_imem_req), .imem_addr(hi_imem_addr),
    .imem_rdata(hi_imem_rdata), .imem_ready(imem_ready),
    .instr(hi_instr), .opcode(hi_opcode), .instr_valid(hi_instr_valid),
    .instr_ready(instr_ready), .pc(hi_pc), .pc_plus4(hi_pc_plus4),
`ifdef IF_PERF_CNT_EN
    .fetch_count(hi_fetch_count), .stall_count(hi_stall_count),
`endif
    .jump(jump), .jump_index(jump_index), .branch(branch),
    .zero(zero), .branch_offset(branch_offset)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; everything after returns 1 time unit past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b0; instr_ready = 1'b0;
    jump = 1'b0; jump_index = 26'h0; branch = 1'b0; zero = 1'b0;
    branch_offset = 16'h0;
    tick(); tick();

    // Reset state
    check("rst_pc",     pc, 32'h0);
    check("rst_instr",  instr, 32'h0);
    check("rst_valid",  {31'b0, instr_valid}, 32'h0);
    check("rst_req",    {31'b0, imem_req}, 32'h0);
    check("rst_opcode", {26'b0, opcode}, 32'h0);
    check("rst_hi_pc",  hi_pc, 32'h4000_0000);

    // Streaming, both handshakes always ready: one instruction per 2 cycles
    rst_n = 1'b1; imem_ready = 1'b1; instr_ready = 1'b1;
    tick();   // BOOT -> FETCH
    check("s1_req0",   {31'b0, imem_req}, 32'h1);
    check("s1_addr0",  imem_addr, 32'h0);
    check("s1_nvalid", {31'b0, instr_valid}, 32'h0);
    tick();   // capture: valid in third cycle after release
    check("s1_valid0", {31'b0, instr_valid}, 32'h1);
    check("s1_instr0", instr, 32'hFFFF_FFFF);
    check("s1_opc0",   {26'b0, opcode}, 32'h3F);
    check("s1_pcp4",   pc_plus4, 32'h4);
    check("s1_reqlo",  {31'b0, imem_req}, 32'h0);
    tick();
    check("s1_addr4",  imem_addr, 32'h4);
    check("s1_vlo",    {31'b0, instr_valid}, 32'h0);
    tick();
    check("s1_instr4", instr, 32'hFFFF_FFFB);
    tick();
    check("s1_addr8",  imem_addr, 32'h8);
    tick();
    tick();
    check("s1_addrC",  imem_addr, 32'hC);

    // Memory response delayed: request and address held
    imem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("s2_req",   {31'b0, imem_req}, 32'h1);
      check("s2_addr",  imem_addr, 32'hC);
      check("s2_valid", {31'b0, instr_valid}, 32'h0);
    end
    imem_ready = 1'b1;
    tick();
    check("s2_valid1", {31'b0, instr_valid}, 32'h1);
    check("s2_instr",  instr, 32'hFFFF_FFF3);
    check("s2_pc",     pc, 32'hC);
    tick();
    check("s2_addr10", imem_addr, 32'h10);
    tick();
    check("s3_pc10",   pc, 32'h10);

    // Taken backward branch: 0x14 + (-16) = 0x4
    branch = 1'b1; zero = 1'b1; branch_offset = 16'hFFFC;
    tick();
    check("s3_brtgt",  imem_addr, 32'h4);
    branch = 1'b0; zero = 1'b0; branch_offset = 16'h0;
    tick();

    // Jump and branch together: jump wins, upper nibble from pc_plus4
    jump = 1'b1; jump_index = 26'h000_0040; branch = 1'b1; zero = 1'b1;
    branch_offset = 16'h0010;
    tick();
    check("s4_jtgt",    imem_addr, 32'h0000_0100);
    check("s4_hi_jtgt", hi_imem_addr, 32'h4000_0100);
    jump = 1'b0; jump_index = 26'h0; branch = 1'b0; zero = 1'b0;
    tick();

    // Branch not taken when zero=0
    branch = 1'b1; zero = 1'b0; branch_offset = 16'h0010;
    tick();
    check("s4_brnt",   imem_addr, 32'h104);
    branch = 1'b0;
    tick();

    // Branch to the last word, then wrap to 0: 0x108 + (-0x10C)
    branch = 1'b1; zero = 1'b1; branch_offset = 16'hFFBD;
    tick();
    check("w_addr",    imem_addr, 32'hFFFF_FFFC);
    branch = 1'b0; zero = 1'b0; branch_offset = 16'h0;
    tick();
    check("w_pc",      pc, 32'hFFFF_FFFC);
    check("w_pcp4",    pc_plus4, 32'h0);
    check("w_instr",   instr, 32'h0000_0003);
    tick();
    check("w_addr0",   imem_addr, 32'h0);
    tick();

    // Decode stall: everything frozen, redirects during stall ignored
    instr_ready = 1'b0; jump = 1'b1; jump_index = 26'h3FF_FFFF;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("s5_instr", instr, 32'hFFFF_FFFF);
      check("s5_pc",    pc, 32'h0);
      check("s5_valid", {31'b0, instr_valid}, 32'h1);
      check("s5_req",   {31'b0, imem_req}, 32'h0);
    end
`ifdef IF_PERF_CNT_EN
    check("s5_stalls", stall_count, 32'd4);
`endif
    jump = 1'b0; jump_index = 26'h0; instr_ready = 1'b1;
    tick();
    check("s5_addr4",  imem_addr, 32'h4);

    // Reset during FETCH with a coincident memory response
    rst_n = 1'b0; imem_ready = 1'b1;
    tick();
    check("s6_instr",  instr, 32'h0);
    check("s6_valid",  {31'b0, instr_valid}, 32'h0);
    check("s6_pc",     pc, 32'h0);
    check("s6_req",    {31'b0, imem_req}, 32'h0);
    rst_n = 1'b1;
    tick();   // BOOT ignores the response still on imem_ready
    check("s6_boot_v", {31'b0, instr_valid}, 32'h0);
    check("s6_req1",   {31'b0, imem_req}, 32'h1);
    check("s6_addr",   imem_addr, 32'h0);
    tick();
    check("s6_cap",    instr, 32'hFFFF_FFFF);
    check("s6_valid1", {31'b0, instr_valid}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
